// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between the core (port 0)
// and the debug/DMA loader (port 1), with RMW bus lock and a post-reset clear sweep.
module mem_arbiter #(
    parameter int WIDTH          = 8,
    parameter int A_WIDTH        = 10,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req0_valid,
    input  logic               req0_we,
    input  logic               req0_lock,
    input  logic [A_WIDTH-1:0] req0_addr,
    input  logic [WIDTH-1:0]   req0_wdata,
    output logic               req0_ready,
    output logic               req0_rvalid,
    output logic [WIDTH-1:0]   req0_rdata,
    input  logic               req1_valid,
    input  logic               req1_we,
    input  logic               req1_lock,
    input  logic [A_WIDTH-1:0] req1_addr,
    input  logic [WIDTH-1:0]   req1_wdata,
    output logic               req1_ready,
    output logic               req1_rvalid,
    output logic [WIDTH-1:0]   req1_rdata,
    output logic [A_WIDTH-1:0] mem_addr,
    output logic               mem_ce,
    output logic [WIDTH-1:0]   mem_wdata,
    input  logic [WIDTH-1:0]   mem_rdata,
    output logic               clearing
);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t             state;
    logic [A_WIDTH-1:0] clr_cnt;
    logic               last;
    logic               lock_held;
    logic               lock_port;
    logic               rvalid0_q;
    logic               rvalid1_q;
    logic               grant0;
    logic               grant1;

    // last=1 means port 1 won most recently, so port 0 is favoured on a tie
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (rst_n && state == RUN) begin
            if (lock_held) begin
                grant0 = !lock_port && req0_valid;
                grant1 = lock_port && req1_valid;
            end else if (req0_valid && req1_valid) begin
                grant0 = last;
                grant1 = !last;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    always_comb begin
        mem_ce    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (rst_n && state == CLEAR) begin
            mem_ce   = 1'b1;
            mem_addr = clr_cnt;
        end else if (grant0) begin
            mem_ce    = req0_we;
            mem_addr  = req0_addr;
            mem_wdata = req0_we ? req0_wdata : '0;
        end else if (grant1) begin
            mem_ce    = req1_we;
            mem_addr  = req1_addr;
            mem_wdata = req1_we ? req1_wdata : '0;
        end
    end

    assign req0_ready  = grant0;
    assign req1_ready  = grant1;
    assign clearing    = rst_n && state == CLEAR;
    // a read response registered just before reset must not be seen during reset
    assign req0_rvalid = rvalid0_q && rst_n;
    assign req1_rvalid = rvalid1_q && rst_n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            if (CLEAR_ON_RESET) state <= CLEAR;
            else                state <= RUN;
            clr_cnt    <= '0;
            last       <= 1'b1;
            lock_held  <= 1'b0;
            lock_port  <= 1'b0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
            req0_rdata <= '0;
            req1_rdata <= '0;
        end else begin
            rvalid0_q <= grant0 && !req0_we;
            rvalid1_q <= grant1 && !req1_we;
            if (grant0 && !req0_we) req0_rdata <= mem_rdata;
            if (grant1 && !req1_we) req1_rdata <= mem_rdata;
            case (state)
                CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == '1) state <= RUN;
                end
                RUN: begin
                    if (grant0) begin
                        last      <= 1'b0;
                        lock_held <= req0_lock;
                        lock_port <= 1'b0;
                    end else if (grant1) begin
                        last      <= 1'b1;
                        lock_held <= req1_lock;
                        lock_port <= 1'b1;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter: a behavioural arbitration/memory model
// predicts grants and bus activity, and read responses are checked from a queue.
module tb_mem_arbiter;

    localparam int W     = 8;
    localparam int AW    = 6;
    localparam int DEPTH = 64;
    localparam int NAW   = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          req0_valid, req0_we, req0_lock, req0_ready, req0_rvalid;
    logic [AW-1:0] req0_addr;
    logic [W-1:0]  req0_wdata, req0_rdata;
    logic          req1_valid, req1_we, req1_lock, req1_ready, req1_rvalid;
    logic [AW-1:0] req1_addr;
    logic [W-1:0]  req1_wdata, req1_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_ce, clearing;
    logic [W-1:0]  mem_wdata, mem_rdata;
    logic [W-1:0]  mem_array [DEPTH];

    logic           n_rst_n;
    logic           n_req0_valid, n_req0_we, n_req0_lock, n_req0_ready, n_req0_rvalid;
    logic [NAW-1:0] n_req0_addr;
    logic [W-1:0]   n_req0_wdata, n_req0_rdata;
    logic           n_req1_valid, n_req1_we, n_req1_lock, n_req1_ready, n_req1_rvalid;
    logic [NAW-1:0] n_req1_addr;
    logic [W-1:0]   n_req1_wdata, n_req1_rdata;
    logic [NAW-1:0] n_mem_addr;
    logic           n_mem_ce, n_clearing;
    logic [W-1:0]   n_mem_wdata, n_mem_rdata;
    logic [W-1:0]   n_mem_array [16];

    mem_arbiter #(.WIDTH(W), .A_WIDTH(AW), .CLEAR_ON_RESET(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_we(req0_we), .req0_lock(req0_lock),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_ready(req0_ready),
        .req0_rvalid(req0_rvalid), .req0_rdata(req0_rdata),
        .req1_valid(req1_valid), .req1_we(req1_we), .req1_lock(req1_lock),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_ready(req1_ready),
        .req1_rvalid(req1_rvalid), .req1_rdata(req1_rdata),
        .mem_addr(mem_addr), .mem_ce(mem_ce), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .clearing(clearing)
    );

    mem_arbiter #(.WIDTH(W), .A_WIDTH(NAW), .CLEAR_ON_RESET(1'b0)) dut_noclr (
        .clk(clk), .rst_n(n_rst_n),
        .req0_valid(n_req0_valid), .req0_we(n_req0_we), .req0_lock(n_req0_lock),
        .req0_addr(n_req0_addr), .req0_wdata(n_req0_wdata), .req0_ready(n_req0_ready),
        .req0_rvalid(n_req0_rvalid), .req0_rdata(n_req0_rdata),
        .req1_valid(n_req1_valid), .req1_we(n_req1_we), .req1_lock(n_req1_lock),
        .req1_addr(n_req1_addr), .req1_wdata(n_req1_wdata), .req1_ready(n_req1_ready),
        .req1_rvalid(n_req1_rvalid), .req1_rdata(n_req1_rdata),
        .mem_addr(n_mem_addr), .mem_ce(n_mem_ce), .mem_wdata(n_mem_wdata),
        .mem_rdata(n_mem_rdata), .clearing(n_clearing)
    );

    assign mem_rdata   = mem_array[mem_addr];
    assign n_mem_rdata = n_mem_array[n_mem_addr];
    always @(posedge clk) if (mem_ce) mem_array[mem_addr] <= mem_wdata;
    always @(posedge clk) if (n_mem_ce) n_mem_array[n_mem_addr] <= n_mem_wdata;

    int checks_total  = 0;
    int checks_passed = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] data;
        int           due;
    } exp_t;

    exp_t         rq0[$];
    exp_t         rq1[$];
    logic [W-1:0] ref_mem [DEPTH];
    bit           m_in_clear;
    int           m_clr_idx;
    int           m_last;
    int           m_owner;
    bit           acc0, acc1;

    task automatic check_output(input string name, input logic [63:0] actual,
                                input logic [63:0] expected);
        checks_total++;
        if (actual === expected) checks_passed++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                      name, actual, expected, cyc);
    endtask

    task automatic apply_stimulus(input logic v0, we0, lk0, input logic [AW-1:0] a0,
                                  input logic [W-1:0] d0,
                                  input logic v1, we1, lk1, input logic [AW-1:0] a1,
                                  input logic [W-1:0] d1);
        @(posedge clk);
        #1;
        req0_valid = v0; req0_we = we0; req0_lock = lk0; req0_addr = a0; req0_wdata = d0;
        req1_valid = v1; req1_we = we1; req1_lock = lk1; req1_addr = a1; req1_wdata = d1;
    endtask

    // Reference model: predicts the winner from valids, lock owner and last winner,
    // then the bus it should drive, and queues the expected read response.
    always @(negedge clk) begin : model_check
        int           win;
        logic         we, lk;
        logic [AW-1:0] a;
        logic [W-1:0] d;
        exp_t         e;
        if (!rst_n) begin
            check_output("reset_outputs",
                         {req0_ready, req1_ready, mem_ce, clearing, req0_rvalid, req1_rvalid},
                         6'b0);
            m_in_clear = 1'b1;
            m_clr_idx  = 0;
            m_last     = 1;
            m_owner    = -1;
            rq0.delete();
            rq1.delete();
            acc0 = 1'b0;
            acc1 = 1'b0;
        end else if (m_in_clear) begin
            check_output("clear_sweep",
                         {clearing, mem_ce, req0_ready, req1_ready, mem_addr, mem_wdata},
                         {4'b1100, 6'(m_clr_idx), 8'h00});
            ref_mem[m_clr_idx] = '0;
            if (m_clr_idx == DEPTH - 1) m_in_clear = 1'b0;
            m_clr_idx++;
            acc0 = 1'b0;
            acc1 = 1'b0;
        end else begin
            win = -1;
            if (m_owner >= 0) begin
                if (m_owner == 0 && req0_valid) win = 0;
                else if (m_owner == 1 && req1_valid) win = 1;
            end else if (req0_valid && req1_valid) win = 1 - m_last;
            else if (req0_valid) win = 0;
            else if (req1_valid) win = 1;
            check_output("grant", {clearing, req1_ready, req0_ready},
                         {1'b0, win == 1, win == 0});
            if (win < 0) begin
                check_output("idle_bus", {mem_ce, mem_addr, mem_wdata}, '0);
            end else begin
                we = (win == 1) ? req1_we   : req0_we;
                lk = (win == 1) ? req1_lock : req0_lock;
                a  = (win == 1) ? req1_addr : req0_addr;
                d  = (win == 1) ? req1_wdata : req0_wdata;
                if (we) begin
                    check_output("write_bus", {mem_ce, mem_addr, mem_wdata}, {1'b1, a, d});
                    ref_mem[a] = d;
                end else begin
                    check_output("read_bus", {mem_ce, mem_addr}, {1'b0, a});
                    e.data = ref_mem[a];
                    e.due  = cyc + 1;
                    if (win == 1) rq1.push_back(e);
                    else          rq0.push_back(e);
                end
                m_last  = win;
                m_owner = lk ? win : -1;
            end
            acc0 = (win == 0);
            acc1 = (win == 1);
        end
    end

    // Response monitor: pops the scoreboard whenever a port presents rvalid.
    always @(negedge clk) begin : resp_check
        logic [W-1:0] exp_rd0, exp_rd1;
        exp_t         e;
        bit           late;
        if (!rst_n) begin
            exp_rd0 = '0;
            exp_rd1 = '0;
        end else begin
            if (req0_rvalid) begin
                check_output("rvalid0_pending", rq0.size() != 0, 1'b1);
                if (rq0.size() != 0) begin
                    e = rq0.pop_front();
                    check_output("rvalid0_cycle", cyc, e.due);
                    check_output("rdata0", req0_rdata, e.data);
                    exp_rd0 = e.data;
                end
            end else begin
                check_output("rdata0_hold", req0_rdata, exp_rd0);
                late = rq0.size() != 0 && rq0[0].due <= cyc;
                check_output("rvalid0_missing", late, 1'b0);
                if (late) void'(rq0.pop_front());
            end
            if (req1_rvalid) begin
                check_output("rvalid1_pending", rq1.size() != 0, 1'b1);
                if (rq1.size() != 0) begin
                    e = rq1.pop_front();
                    check_output("rvalid1_cycle", cyc, e.due);
                    check_output("rdata1", req1_rdata, e.data);
                    exp_rd1 = e.data;
                end
            end else begin
                check_output("rdata1_hold", req1_rdata, exp_rd1);
                late = rq1.size() != 0 && rq1[0].due <= cyc;
                check_output("rvalid1_missing", late, 1'b0);
                if (late) void'(rq1.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        {req0_valid, req0_we, req0_lock, req0_addr, req0_wdata} = '0;
        {req1_valid, req1_we, req1_lock, req1_addr, req1_wdata} = '0;
        n_rst_n = 1'b0;
        {n_req0_valid, n_req0_we, n_req0_lock, n_req0_addr, n_req0_wdata} = '0;
        {n_req1_valid, n_req1_we, n_req1_lock, n_req1_addr, n_req1_wdata} = '0;
        for (int i = 0; i < DEPTH; i++) begin
            mem_array[i] = 8'hAA;
            ref_mem[i]   = 8'hAA;
        end
        for (int i = 0; i < 16; i++) n_mem_array[i] = 8'(i * 7 + 1);
        repeat (2) @(posedge clk);

        // Both ports wait through the sweep, then must alternate starting with port 0
        #1;
        rst_n = 1'b1;
        req0_valid = 1'b1; req0_addr = 6'd5;
        req1_valid = 1'b1; req1_addr = 6'd9;
        repeat (DEPTH + 6) @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        apply_stimulus(1, 1, 0, 6'h12, 8'h3C, 0, 0, 0, 6'h00, 8'h00);
        apply_stimulus(1, 0, 0, 6'h12, 8'h00, 0, 0, 0, 6'h00, 8'h00);
        apply_stimulus(0, 0, 0, 6'h00, 8'h00, 0, 0, 0, 6'h00, 8'h00);

        // Port 1 locks 0x20 for a read-modify-write while port 0 waits
        apply_stimulus(1, 0, 0, 6'h01, 8'h00, 1, 0, 1, 6'h20, 8'h00);
        apply_stimulus(1, 0, 0, 6'h01, 8'h00, 0, 0, 0, 6'h00, 8'h00);
        apply_stimulus(1, 0, 0, 6'h01, 8'h00, 1, 1, 0, 6'h20, 8'h77);
        apply_stimulus(1, 0, 0, 6'h01, 8'h00, 0, 0, 0, 6'h00, 8'h00);
        apply_stimulus(0, 0, 0, 6'h20, 8'h00, 1, 0, 0, 6'h20, 8'h00);
        apply_stimulus(0, 0, 0, 6'h00, 8'h00, 0, 0, 0, 6'h00, 8'h00);

        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            if (!(req0_valid && !acc0)) begin
                req0_valid = $urandom_range(0, 2) != 0;
                req0_we    = $urandom_range(0, 1) != 0;
                req0_lock  = $urandom_range(0, 3) == 0;
                req0_addr  = 6'($urandom_range(0, DEPTH - 1));
                req0_wdata = 8'($urandom);
            end
            if (!(req1_valid && !acc1)) begin
                req1_valid = $urandom_range(0, 2) != 0;
                req1_we    = $urandom_range(0, 1) != 0;
                req1_lock  = $urandom_range(0, 3) == 0;
                req1_addr  = 6'($urandom_range(0, DEPTH - 1));
                req1_wdata = 8'($urandom);
            end
        end
        repeat (3) apply_stimulus(1, 0, 0, 6'h02, 8'h00, 1, 0, 0, 6'h03, 8'h00);
        apply_stimulus(0, 0, 0, 6'h00, 8'h00, 0, 0, 0, 6'h00, 8'h00);

        // Reset while port 1 holds the lock and its read response is pending
        apply_stimulus(0, 0, 0, 6'h00, 8'h00, 1, 0, 1, 6'h05, 8'h00);
        apply_stimulus(1, 0, 0, 6'h06, 8'h00, 1, 0, 1, 6'h07, 8'h00);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_we = 1'b0; req0_lock = 1'b0; req0_addr = 6'h03;
        repeat (DEPTH + 1) @(posedge clk);
        #1;
        req0_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("drain", rq0.size() + rq1.size(), 0);

        // Instance without a sweep grants port 1 on the first cycle out of reset
        @(posedge clk);
        #1;
        n_rst_n = 1'b1;
        n_req1_valid = 1'b1; n_req1_addr = 4'd3;
        @(negedge clk);
        check_output("noclr_grant", {n_clearing, n_req0_ready, n_req1_ready}, 3'b001);
        check_output("noclr_bus", {n_mem_ce, n_mem_addr}, {1'b0, 4'd3});
        @(posedge clk);
        #1;
        n_req1_valid = 1'b0;
        @(negedge clk);
        check_output("noclr_rvalid", {n_req1_rvalid, n_req0_rvalid}, 2'b10);
        check_output("noclr_rdata", n_req1_rdata, 8'(3 * 7 + 1));

        $display("[TB] %0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
